dmem_access: RTL and testbench

Data-memory access unit for the MEM stage of the 5-stage MIPS pipeline. It takes the EX/MEM control, address and store data, services loads from a direct-mapped, write-through data cache backed by a req/ack memory port, and produces the load data and `hit` stall qualifier consumed by the MEM/WB register. The MEM/WB register latches only when `hit` = 1. While `hit` = 0 the upstream pipeline holds its inputs stable.

---
 rtl/dmem_access_if.sv | 20 ++
 rtl/dmem_access.sv | 117 +++++++++++
 tb/tb_dmem_access.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dmem_access_if.sv
// Backing-memory req/ack port of the MEM-stage data cache.
// master = cache side, slave = memory side.
interface dmem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_access.sv
// MEM-stage data access: direct-mapped write-through, no-write-allocate cache
// with a req/ack backing port; hit qualifies the MEM/WB latch.
module dmem_access #(
    parameter int unsigned LINES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_ctlmem,
    input  logic [31:0]         ialu_result,
    input  logic [31:0]         iwrite_data,
    output logic [31:0]         oread_data_mem,
    output logic                hit,
    dmem_access_if.master       mem
);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, DONE} state_t;

    state_t             state;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];
    logic [31:0]        fill_q;
    logic               done_rd_q;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               is_write;
    logic               is_read;
    logic               line_hit;
    logic               unused_addr_lsb;

    assign idx             = ialu_result[IDX_W+1:2];
    assign tag             = ialu_result[31:IDX_W+2];
    assign is_write        = i_ctlmem[0];
    assign is_read         = i_ctlmem[1] & ~i_ctlmem[0];
    assign line_hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign unused_addr_lsb = ^ialu_result[1:0];

    always_comb begin
        hit            = 1'b0;
        oread_data_mem = '0;
        if (rst) begin
            hit = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (is_write) begin
                        hit = 1'b0;
                    end else if (is_read) begin
                        hit = line_hit;
                        if (line_hit) oread_data_mem = data_q[idx];
                    end else begin
                        hit = 1'b1;
                    end
                end
                DONE: begin
                    hit = 1'b1;
                    if (done_rd_q) oread_data_mem = fill_q;
                end
                default: hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid_q       <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            fill_q        <= '0;
            done_rd_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_write) begin
                        state         <= WR_MEM;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= {ialu_result[31:2], 2'b00};
                        mem.mem_wdata <= iwrite_data;
                    end else if (is_read && !line_hit) begin
                        state        <= RD_MISS;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= {ialu_result[31:2], 2'b00};
                    end
                end
                RD_MISS: begin
                    if (mem.mem_ack) begin
                        valid_q[idx] <= 1'b1;
                        tag_q[idx]   <= tag;
                        data_q[idx]  <= mem.mem_rdata;
                        fill_q       <= mem.mem_rdata;
                        done_rd_q    <= 1'b1;
                        mem.mem_req  <= 1'b0;
                        state        <= DONE;
                    end
                end
                WR_MEM: begin
                    if (mem.mem_ack) begin
                        // write-update only; a miss leaves the resident line alone
                        if (line_hit) data_q[idx] <= iwrite_data;
                        done_rd_q   <= 1'b0;
                        mem.mem_req <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access.sv
// Bench for dmem_access: directed plan steps plus random ops against a
// word-addressed cache/memory model.
module tb_dmem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_ctlmem;
    logic [31:0] ialu_result;
    logic [31:0] iwrite_data;
    logic [31:0] oread_data_mem;
    logic        hit;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    dmem_access_if mem_bus ();

    dmem_access #(.LINES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_ctlmem       (i_ctlmem),
        .ialu_result    (ialu_result),
        .iwrite_data    (iwrite_data),
        .oread_data_mem (oread_data_mem),
        .hit            (hit),
        .mem            (mem_bus)
    );

    always #5 clk = ~clk;

    // model: each line remembers the full word address it holds
    bit          line_v [16];
    logic [29:0] line_w [16];
    logic [31:0] line_d [16];
    logic [31:0] mem_model [logic [29:0]];

    function automatic logic [31:0] mem_value(input logic [29:0] word);
        if (mem_model.exists(word)) return mem_model[word];
        return {word, 2'b01} ^ 32'hA5A5_0000;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) line_v[i] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op; memory acks on the k-th request cycle.
    task automatic op(input logic [1:0] ctl, input logic [31:0] addr,
                      input logic [31:0] wd, input int unsigned k);
        int unsigned idx;
        logic [29:0] word;
        bit          is_rd, mhit;
        logic [31:0] fetch, exp_data;
        int unsigned last;
        word     = addr[31:2];
        idx      = int'(word % 16);
        is_rd    = (ctl == 2'b10);
        mhit     = is_rd && line_v[idx] && (line_w[idx] == word);
        fetch    = mem_value(word);
        last     = (ctl == 2'b00 || mhit) ? 0 : k + 1;
        exp_data = !is_rd ? 32'h0 : (mhit ? line_d[idx] : fetch);
        i_ctlmem    = ctl;
        ialu_result = addr;
        iwrite_data = wd;
        for (int unsigned c = 0; c <= last; c++) begin
            @(negedge clk);
            check("hit", {31'b0, hit}, {31'b0, c == last});
            check("mem_req", {31'b0, mem_bus.mem_req}, {31'b0, last != 0 && c >= 1 && c <= k});
            if (last != 0 && c >= 1 && c <= k) begin
                check("mem_addr", mem_bus.mem_addr, {word, 2'b00});
                check("mem_we", {31'b0, mem_bus.mem_we}, {31'b0, ctl[0]});
                if (ctl[0]) check("mem_wdata", mem_bus.mem_wdata, wd);
            end
            if (c == last) check("read_data", oread_data_mem, exp_data);
            if (last != 0 && c == k) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = fetch;
            end
            @(posedge clk);
            #1;
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = $urandom;
        end
        if (ctl[0]) begin
            mem_model[word] = wd;
            if (line_v[idx] && line_w[idx] == word) line_d[idx] = wd;
        end else if (is_rd && !mhit) begin
            line_v[idx] = 1'b1;
            line_w[idx] = word;
            line_d[idx] = fetch;
        end
        i_ctlmem = 2'b00;
    endtask

    initial begin
        logic [31:0] a;
        rst               = 1'b1;
        i_ctlmem          = 2'b00;
        ialu_result       = '0;
        iwrite_data       = '0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        clear_model();
        mem_model[30'h40] = 32'hDEADBEEF;
        mem_model[30'h50] = 32'h11111111;

        // reset held for two edges
        @(negedge clk);
        check("rst_hit", {31'b0, hit}, 32'd1);
        check("rst_rdata", oread_data_mem, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
        check("rst_addr", mem_bus.mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        op(2'b10, 32'h40, 32'h0, 1);
        op(2'b10, 32'h100, 32'h0, 3);          // cold miss, DEADBEEF
        op(2'b10, 32'h100, 32'h0, 1);          // hit
        op(2'b01, 32'h102, 32'hCAFEF00D, 2);   // write-update
        op(2'b10, 32'h100, 32'h0, 1);          // hit, updated
        op(2'b00, 32'h100, 32'h12345678, 1);   // idle
        op(2'b01, 32'h200, 32'h01020304, 1);   // write miss, no allocate
        op(2'b10, 32'h200, 32'h0, 2);          // must miss
        op(2'b10, 32'h140, 32'h0, 1);          // conflict fill
        op(2'b10, 32'h100, 32'h0, 2);          // refetch
        op(2'b11, 32'h140, 32'h77777777, 1);   // 2'b11 is a write, line now 0x100

        // reset mid-miss with a late ack
        i_ctlmem    = 2'b10;
        ialu_result = 32'h80;
        @(negedge clk);
        check("mm_detect_hit", {31'b0, hit}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mm_req1", {31'b0, mem_bus.mem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mm_rst_hit", {31'b0, hit}, 32'd1);
        check("mm_rst_rdata", oread_data_mem, 32'h0);
        @(posedge clk); #1;
        rst               = 1'b0;
        i_ctlmem          = 2'b00;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h55555555;
        @(negedge clk);
        check("mm_req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
        check("mm_idle_hit", {31'b0, hit}, 32'd1);
        @(posedge clk); #1;
        mem_bus.mem_ack = 1'b0;
        clear_model();
        op(2'b10, 32'h80, 32'h0, 2);
        op(2'b10, 32'h100, 32'h0, 1);

        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) * 32'h40) + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_0000;
            op(2'($urandom_range(0, 3)), a, $urandom, $urandom_range(1, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
